// File: rtl/ooop_types.sv
// Shared out-of-order pipeline types: rename packets, reservation-station entries,
// functional-unit encodings and the packet-to-RS-entry mapping used by dispatch logic.
package ooop_types;

    typedef logic [1:0] fu_type_t;

    localparam fu_type_t FU_ALU = 2'd0;
    localparam fu_type_t FU_BRU = 2'd1;
    localparam fu_type_t FU_LSU = 2'd2;

    typedef logic [4:0] rob_tag_t;
    typedef logic [5:0] preg_t;

    typedef struct packed {
        fu_type_t   fu_type;
        logic [3:0] op;
        preg_t      rd;
        preg_t      rs1;
        logic       rs1_ready;
        preg_t      rs2;
        logic       rs2_ready;
        logic [15:0] imm;
        rob_tag_t   rob_tag;
    } rename_pkt_t;

    typedef struct packed {
        logic       valid;
        fu_type_t   fu_type;
        logic [3:0] op;
        preg_t      rd;
        preg_t      rs1;
        logic       rs1_ready;
        preg_t      rs2;
        logic       rs2_ready;
        logic [15:0] imm;
        rob_tag_t   rob_tag;
    } rs_entry_t;

    function automatic logic fu_is_legal(input fu_type_t fu);
        return (fu == FU_ALU) || (fu == FU_BRU) || (fu == FU_LSU);
    endfunction

    function automatic rs_entry_t to_rs_entry(input rename_pkt_t pkt);
        rs_entry_t e;
        e.valid     = 1'b1;
        e.fu_type   = pkt.fu_type;
        e.op        = pkt.op;
        e.rd        = pkt.rd;
        e.rs1       = pkt.rs1;
        e.rs1_ready = pkt.rs1_ready;
        e.rs2       = pkt.rs2;
        e.rs2_ready = pkt.rs2_ready;
        e.imm       = pkt.imm;
        e.rob_tag   = pkt.rob_tag;
        return e;
    endfunction

endpackage

// File: rtl/dispatch_ring_buffer.sv
// Generic DEPTH-entry circular FIFO storage with pointers, occupancy count,
// full/empty flags and a synchronous clear. DEPTH must be a power of two.
module dispatch_ring_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    // NOTE: storage is reset here only because entries must read as zero after reset;
    // a larger queue would leave the array unreset and rely on the count instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch from rename into the ALU/BRU/LSU reservation stations and ROB.
// Optional same-cycle bypass of an empty queue is enabled by defining DISPATCH_BYPASS_EN.
module dispatch_queue
    import ooop_types::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  rename_pkt_t                pkt_in,
    input  logic                       rs_alu_ready_i,
    input  logic                       rs_bru_ready_i,
    input  logic                       rs_lsu_ready_i,
    output logic                       rs_alu_valid_o,
    output logic                       rs_bru_valid_o,
    output logic                       rs_lsu_valid_o,
    output rs_entry_t                  rs_alu_entry_o,
    output rs_entry_t                  rs_bru_entry_o,
    output rs_entry_t                  rs_lsu_entry_o,
    input  logic                       rob_ready_i,
    output logic                       rob_alloc_valid_o,
    output rename_pkt_t                rob_alloc_pkt_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [CNT_W-1:0]           stall_rob_cnt_o,
    output logic [CNT_W-1:0]           stall_rs_cnt_o,
    output logic                       bad_fu_o
);

    logic        push;
    logic        pop;
    logic        fire;
    logic        bypass;
    logic        rs_space_ok;
    logic        full;
    logic        empty;
    logic        head_legal;
    rename_pkt_t q_head;
    rename_pkt_t head;

    dispatch_ring_buffer #(
        .DEPTH (DEPTH),
        .W     ($bits(rename_pkt_t))
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clear (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (pkt_in),
        .rdata (q_head),
        .count (occupancy_o),
        .full  (full),
        .empty (empty)
    );

`ifdef DISPATCH_BYPASS_EN
    assign bypass = empty && valid_in && !flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign head       = bypass ? pkt_in : q_head;
    assign head_legal = fu_is_legal(head.fu_type);
    assign ready_out  = !full && !flush_i;

    always_comb begin
        case (head.fu_type)
            FU_ALU:  rs_space_ok = rs_alu_ready_i;
            FU_BRU:  rs_space_ok = rs_bru_ready_i;
            FU_LSU:  rs_space_ok = rs_lsu_ready_i;
            default: rs_space_ok = 1'b0;
        endcase
    end

    assign fire = (!empty || bypass) && rob_ready_i && rs_space_ok && !flush_i;
    // A bypassed packet that fires never touches the storage.
    assign pop  = fire && !bypass;
    assign push = valid_in && ready_out && !(bypass && fire);

    assign rob_alloc_valid_o = fire;
    assign rob_alloc_pkt_o   = head;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        rs_alu_valid_o = 1'b0;
        rs_bru_valid_o = 1'b0;
        rs_lsu_valid_o = 1'b0;
        rs_alu_entry_o = '0;
        rs_bru_entry_o = '0;
        rs_lsu_entry_o = '0;
        if (fire) begin
            case (head.fu_type)
                FU_ALU: begin
                    rs_alu_valid_o = 1'b1;
                    rs_alu_entry_o = to_rs_entry(head);
                end
                FU_BRU: begin
                    rs_bru_valid_o = 1'b1;
                    rs_bru_entry_o = to_rs_entry(head);
                end
                FU_LSU: begin
                    rs_lsu_valid_o = 1'b1;
                    rs_lsu_entry_o = to_rs_entry(head);
                end
                default: ;
            endcase
        end
    end

    // Stall accounting looks only at a queued head, so bypass attempts never count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_rob_cnt_o <= '0;
            stall_rs_cnt_o  <= '0;
            bad_fu_o        <= 1'b0;
        end else begin
            if (!empty && !fire && !flush_i) begin
                if (!rob_ready_i) begin
                    if (stall_rob_cnt_o != '1) stall_rob_cnt_o <= stall_rob_cnt_o + 1'b1;
                end else if (!rs_space_ok && head_legal) begin
                    if (stall_rs_cnt_o != '1) stall_rs_cnt_o <= stall_rs_cnt_o + 1'b1;
                end
            end
            if (!empty && !head_legal) begin
                bad_fu_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized self-checking bench for dispatch_queue against a queue-based reference model.
// Honours DISPATCH_BYPASS_EN in the same way as the design build.
module tb_dispatch_queue;
    import ooop_types::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int OW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic              valid_in;
    logic              ready_out;
    rename_pkt_t       pkt_in;
    logic              rs_alu_ready_i, rs_bru_ready_i, rs_lsu_ready_i;
    logic              rs_alu_valid_o, rs_bru_valid_o, rs_lsu_valid_o;
    rs_entry_t         rs_alu_entry_o, rs_bru_entry_o, rs_lsu_entry_o;
    logic              rob_ready_i;
    logic              rob_alloc_valid_o;
    rename_pkt_t       rob_alloc_pkt_o;
    logic [OW-1:0]     occupancy_o;
    logic [CNT_W-1:0]  stall_rob_cnt_o;
    logic [CNT_W-1:0]  stall_rs_cnt_o;
    logic              bad_fu_o;

    dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .valid_in          (valid_in),
        .ready_out         (ready_out),
        .pkt_in            (pkt_in),
        .rs_alu_ready_i    (rs_alu_ready_i),
        .rs_bru_ready_i    (rs_bru_ready_i),
        .rs_lsu_ready_i    (rs_lsu_ready_i),
        .rs_alu_valid_o    (rs_alu_valid_o),
        .rs_bru_valid_o    (rs_bru_valid_o),
        .rs_lsu_valid_o    (rs_lsu_valid_o),
        .rs_alu_entry_o    (rs_alu_entry_o),
        .rs_bru_entry_o    (rs_bru_entry_o),
        .rs_lsu_entry_o    (rs_lsu_entry_o),
        .rob_ready_i       (rob_ready_i),
        .rob_alloc_valid_o (rob_alloc_valid_o),
        .rob_alloc_pkt_o   (rob_alloc_pkt_o),
        .occupancy_o       (occupancy_o),
        .stall_rob_cnt_o   (stall_rob_cnt_o),
        .stall_rs_cnt_o    (stall_rs_cnt_o),
        .bad_fu_o          (bad_fu_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the queue contents, the two stall counters and the sticky flag.
    rename_pkt_t      m_q[$];
    logic [CNT_W-1:0] m_rob_cnt;
    logic [CNT_W-1:0] m_rs_cnt;
    bit               m_bad;
    int               tag_seq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rs_entry_t exp_entry(input rename_pkt_t p);
        rs_entry_t e;
        e = '{valid: 1'b1, fu_type: p.fu_type, op: p.op, rd: p.rd, rs1: p.rs1,
              rs1_ready: p.rs1_ready, rs2: p.rs2, rs2_ready: p.rs2_ready,
              imm: p.imm, rob_tag: p.rob_tag};
        return e;
    endfunction

    function automatic rename_pkt_t make_pkt(input fu_type_t fu);
        rename_pkt_t p;
        p.fu_type   = fu;
        p.op        = 4'($urandom);
        p.rd        = 6'($urandom);
        p.rs1       = 6'($urandom);
        p.rs1_ready = 1'($urandom);
        p.rs2       = 6'($urandom);
        p.rs2_ready = 1'($urandom);
        p.imm       = 16'($urandom);
        p.rob_tag   = 5'(tag_seq);
        tag_seq++;
        return p;
    endfunction

    function automatic bit legal(input fu_type_t fu);
        return fu == FU_ALU || fu == FU_BRU || fu == FU_LSU;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rob_cnt = '0;
        m_rs_cnt  = '0;
        m_bad     = 1'b0;
    endtask

    // One clock: drive at the falling edge, compare just after, then advance the model.
    task automatic step(input bit v, input rename_pkt_t p, input bit fl,
                        input bit a, input bit b, input bit l, input bit r);
        bit          byp, ok, fire, rdy;
        int          n;
        rename_pkt_t h;
        rs_entry_t   zero_e;
        zero_e = '0;
        @(negedge clk);
        valid_in = v; pkt_in = p; flush_i = fl;
        rs_alu_ready_i = a; rs_bru_ready_i = b; rs_lsu_ready_i = l; rob_ready_i = r;
        #1;
        n   = m_q.size();
        byp = 1'b0;
`ifdef DISPATCH_BYPASS_EN
        byp = (n == 0) && v && !fl;
`endif
        h    = byp ? p : (n != 0 ? m_q[0] : '0);
        ok   = (h.fu_type == FU_ALU) ? a : (h.fu_type == FU_BRU) ? b : (h.fu_type == FU_LSU) ? l : 1'b0;
        fire = (n != 0 || byp) && r && ok && !fl;
        rdy  = (n < DEPTH) && !fl;

        check("ready_out", 64'(ready_out), 64'(rdy));
        check("occupancy", 64'(occupancy_o), 64'(n));
        check("rob_valid", 64'(rob_alloc_valid_o), 64'(fire));
        check("alu_valid", 64'(rs_alu_valid_o), 64'(fire && h.fu_type == FU_ALU));
        check("bru_valid", 64'(rs_bru_valid_o), 64'(fire && h.fu_type == FU_BRU));
        check("lsu_valid", 64'(rs_lsu_valid_o), 64'(fire && h.fu_type == FU_LSU));
        check("alu_entry", 64'(rs_alu_entry_o), 64'((fire && h.fu_type == FU_ALU) ? exp_entry(h) : zero_e));
        check("bru_entry", 64'(rs_bru_entry_o), 64'((fire && h.fu_type == FU_BRU) ? exp_entry(h) : zero_e));
        check("lsu_entry", 64'(rs_lsu_entry_o), 64'((fire && h.fu_type == FU_LSU) ? exp_entry(h) : zero_e));
        if (fire) check("rob_pkt", 64'(rob_alloc_pkt_o), 64'(h));
        check("stall_rob", 64'(stall_rob_cnt_o), 64'(m_rob_cnt));
        check("stall_rs", 64'(stall_rs_cnt_o), 64'(m_rs_cnt));
        check("bad_fu", 64'(bad_fu_o), 64'(m_bad));

        if (n != 0 && !fire && !fl) begin
            if (!r) begin
                if (m_rob_cnt != '1) m_rob_cnt++;
            end else if (!ok && legal(h.fu_type)) begin
                if (m_rs_cnt != '1) m_rs_cnt++;
            end
        end
        if (n != 0 && !legal(h.fu_type)) m_bad = 1'b1;
        if (fl) begin
            m_q.delete();
        end else begin
            if (fire && !byp) void'(m_q.pop_front());
            if (v && rdy && !(byp && fire)) m_q.push_back(p);
        end
    endtask

    task automatic idle(input bit a, input bit b, input bit l, input bit r);
        step(1'b0, '0, 1'b0, a, b, l, r);
    endtask

    initial begin
        rename_pkt_t p;
        rst = 1'b1; flush_i = 1'b0; valid_in = 1'b0; pkt_in = '0;
        rs_alu_ready_i = 1'b0; rs_bru_ready_i = 1'b0; rs_lsu_ready_i = 1'b0; rob_ready_i = 1'b0;
        tag_seq = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_occupancy", 64'(occupancy_o), 64'(0));
        check("rst_ready", 64'(ready_out), 64'(1));
        check("rst_rob_valid", 64'(rob_alloc_valid_o), 64'(0));
        check("rst_alu_entry", 64'(rs_alu_entry_o), 64'(0));
        check("rst_stall_rob", 64'(stall_rob_cnt_o), 64'(0));
        check("rst_bad_fu", 64'(bad_fu_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Four ALU packets blocked by a full ALU RS, then drained in order.
        for (int i = 0; i < 4; i++) step(1'b1, make_pkt(FU_ALU), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0, 1'b1, 1'b1, 1'b1);
        check("full_ready_low", 64'(ready_out), 64'(0));
        check("full_occupancy", 64'(occupancy_o), 64'(4));
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Rotating unit types with everything ready.
        for (int i = 0; i < 9; i++) step(1'b1, make_pkt(fu_type_t'(i % 3)), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);

        // ROB back-pressure on a single queued entry.
        step(1'b1, make_pkt(FU_BRU), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 1'b1, 1'b1, 1'b1);

        // Flush with an incoming packet on a three-deep queue.
        for (int i = 0; i < 3; i++) step(1'b1, make_pkt(FU_LSU), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, make_pkt(FU_ALU), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1'b1, 1'b1);
        check("flush_empty", 64'(occupancy_o), 64'(0));

        // Illegal unit type wedges the head until flushed.
        p = make_pkt(FU_ALU);
        p.fu_type = 2'd3;
        step(1'b1, p, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, make_pkt(FU_ALU), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 1'b1, 1'b1);
        check("bad_fu_set", 64'(bad_fu_o), 64'(1));
        step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1, 1'b1, 1'b1);
        check("bad_fu_sticky", 64'(bad_fu_o), 64'(1));

`ifdef DISPATCH_BYPASS_EN
        step(1'b1, make_pkt(FU_LSU), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("bypass_lsu_valid", 64'(rs_lsu_valid_o), 64'(1));
        idle(1'b1, 1'b1, 1'b1, 1'b1);
        check("bypass_occupancy", 64'(occupancy_o), 64'(0));
`endif

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            fu_type_t fu;
            fu = ($urandom_range(0, 99) < 3) ? 2'd3 : fu_type_t'($urandom_range(0, 2));
            step(1'($urandom_range(0, 99) < 65), make_pkt(fu), 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 70),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 75));
        end

        // Fill, then reset asynchronously between clock edges.
        for (int i = 0; i < 3; i++) step(1'b1, make_pkt(FU_ALU), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0; flush_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_occupancy", 64'(occupancy_o), 64'(0));
        check("arst_stall_rob", 64'(stall_rob_cnt_o), 64'(0));
        check("arst_stall_rs", 64'(stall_rs_cnt_o), 64'(0));
        check("arst_bad_fu", 64'(bad_fu_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1, 1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
